// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync_pkg.sv
// Shared definitions for the rxdgl receive-side synchroniser/deglitcher family:
// legal parameter ranges, the registered output bundle and the counter-width helper.
package gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_LEN_MIN    = 1;
    localparam int FILT_LEN_MAX    = 255;

    // Registered output bundle; every field is driven straight from a flop.
    typedef struct packed {
        logic z;
        logic zr;
        logic zf;
        logic qual;
    } rx_out_t;

    // Counter width for a filter of the given length; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rxdgl_syncchain.sv
// Plain multi-flop synchroniser chain with asynchronous active-low reset.
// No logic between stages, so it can be shared by other cross-domain receive cells.
module gf180mcu_fd_sc_mcu7t5v0__rxdgl_syncchain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RN,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] stage;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // value its neighbour held before the edge; blocking here would collapse the chain.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            stage <= {SYNC_STAGES{RST_VAL}};
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], D};
        end
    end

    assign Q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync.sv
// Synchronises asynchronous input I into the CLK domain and rejects glitches shorter
// than FILT_LEN sampled cycles; drives a clean level Z plus rise/fall strobes.
module gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync
    import gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RN,
    input  logic I,
    output logic Z,
    output logic ZR,
    output logic ZF,
    output logic QUAL
);

    localparam int              CNT_W    = clog2_min1(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("rxdgl_sync: SYNC_STAGES=%0d outside legal range", SYNC_STAGES);
    end
    if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
        $error("rxdgl_sync: FILT_LEN=%0d outside legal range", FILT_LEN);
    end

    logic             s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    rx_out_t          out_q;
    rx_out_t          out_nxt;

    gf180mcu_fd_sc_mcu7t5v0__rxdgl_syncchain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_syncchain (
        .CLK (CLK),
        .RN  (RN),
        .D   (I),
        .Q   (s)
    );

    // Implicit two-state machine: STABLE while cnt_q == 0, QUALIFY otherwise.
    // A sample that agrees with Z throws away any partial count.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves
        // one unassigned and no latch is inferred.
        cnt_nxt      = '0;
        out_nxt      = '{z: out_q.z, zr: 1'b0, zf: 1'b0, qual: 1'b0};
        if (s != out_q.z) begin
            if (cnt_q == CNT_LAST) begin
                out_nxt.z  = s;
                out_nxt.zr = s;
                out_nxt.zf = ~s;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
        out_nxt.qual = (cnt_nxt != '0);
    end

    // QUAL is registered from the next count so it matches cnt != 0 with no path from I.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
            out_q <= '{z: RST_VAL, zr: 1'b0, zf: 1'b0, qual: 1'b0};
        end else begin
            cnt_q <= cnt_nxt;
            out_q <= out_nxt;
        end
    end

    assign Z    = out_q.z;
    assign ZR   = out_q.zr;
    assign ZF   = out_q.zf;
    assign QUAL = out_q.qual;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync.sv
// Self-checking bench for the rxdgl synchroniser/deglitcher: a table of per-edge
// vectors for the default build, hand sequences for reset-mid-qualify and FILT_LEN=1.
module tb_gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync;

    typedef struct {
        logic       rn;
        logic       i;
        logic [3:0] exp;   // {Z, ZR, ZF, QUAL} after the edge
        string      tag;
    } vec_t;

    typedef struct {
        string      tag;
        bit         sel;   // 0: default build, 1: FILT_LEN=1/SYNC_STAGES=3 build
        logic [3:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rn;
    logic i_main;
    logic i_alt;
    logic z0, zr0, zf0, qual0;
    logic z1, zr1, zf1, qual1;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync dut (
        .CLK  (clk),
        .RN   (rn),
        .I    (i_main),
        .Z    (z0),
        .ZR   (zr0),
        .ZF   (zf0),
        .QUAL (qual0)
    );

    gf180mcu_fd_sc_mcu7t5v0__rxdgl_sync #(
        .SYNC_STAGES (3),
        .FILT_LEN    (1)
    ) dut_f1 (
        .CLK  (clk),
        .RN   (rn),
        .I    (i_alt),
        .Z    (z1),
        .ZR   (zr1),
        .ZF   (zf1),
        .QUAL (qual1)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: {Z,ZR,ZF,QUAL} got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input logic rn_v, input logic i_v, input logic [3:0] exp,
                                input string tag);
        vecs.push_back('{rn: rn_v, i: i_v, exp: exp, tag: tag});
    endfunction

    // Drive one edge's stimulus on the falling edge, queue its expectation, then
    // compare the selected build's outputs just after the rising edge.
    task automatic step(input logic rn_v, input logic i_v, input logic ia_v,
                        input logic [3:0] exp, input bit sel, input string tag);
        sb_t e;
        @(negedge clk);
        rn     = rn_v;
        i_main = i_v;
        i_alt  = ia_v;
        sb.push_back('{tag: tag, sel: sel, exp: exp});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) check(e.tag, {z1, zr1, zf1, qual1}, e.exp);
        else       check(e.tag, {z0, zr0, zf0, qual0}, e.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   hist[$];
        logic zp;
        logic zk;

        // Reset held three edges, then quiet input.
        for (int k = 0; k < 3; k++)  add(1'b0, 1'b0, 4'b0000, "rst_hold");
        for (int k = 0; k < 10; k++) add(1'b1, 1'b0, 4'b0000, "idle_low");
        // 0->1 held: QUAL on edges 3-5, Z/ZR on edge 6.
        add(1'b1, 1'b1, 4'b0000, "rise_e1");
        add(1'b1, 1'b1, 4'b0000, "rise_e2");
        add(1'b1, 1'b1, 4'b0001, "rise_e3");
        add(1'b1, 1'b1, 4'b0001, "rise_e4");
        add(1'b1, 1'b1, 4'b0001, "rise_e5");
        add(1'b1, 1'b1, 4'b1100, "rise_e6");
        add(1'b1, 1'b1, 4'b1000, "rise_e7");
        add(1'b1, 1'b1, 4'b1000, "rise_e8");
        // 1->0 held: ZF on edge 6.
        add(1'b1, 1'b0, 4'b1000, "fall_e1");
        add(1'b1, 1'b0, 4'b1000, "fall_e2");
        add(1'b1, 1'b0, 4'b1001, "fall_e3");
        add(1'b1, 1'b0, 4'b1001, "fall_e4");
        add(1'b1, 1'b0, 4'b1001, "fall_e5");
        add(1'b1, 1'b0, 4'b0010, "fall_e6");
        add(1'b1, 1'b0, 4'b0000, "fall_e7");
        // Pulse of FILT_LEN-1 sampled cycles is rejected.
        add(1'b1, 1'b1, 4'b0000, "short_e1");
        add(1'b1, 1'b1, 4'b0000, "short_e2");
        add(1'b1, 1'b1, 4'b0001, "short_e3");
        add(1'b1, 1'b0, 4'b0001, "short_e4");
        add(1'b1, 1'b0, 4'b0001, "short_e5");
        add(1'b1, 1'b0, 4'b0000, "short_e6");
        add(1'b1, 1'b0, 4'b0000, "short_e7");
        // Pulse of exactly FILT_LEN cycles: ZR at edge 6, ZF at edge 10.
        add(1'b1, 1'b1, 4'b0000, "exact_e1");
        add(1'b1, 1'b1, 4'b0000, "exact_e2");
        add(1'b1, 1'b1, 4'b0001, "exact_e3");
        add(1'b1, 1'b1, 4'b0001, "exact_e4");
        add(1'b1, 1'b0, 4'b0001, "exact_e5");
        add(1'b1, 1'b0, 4'b1100, "exact_e6");
        add(1'b1, 1'b0, 4'b1001, "exact_e7");
        add(1'b1, 1'b0, 4'b1001, "exact_e8");
        add(1'b1, 1'b0, 4'b1001, "exact_e9");
        add(1'b1, 1'b0, 4'b0010, "exact_e10");
        add(1'b1, 1'b0, 4'b0000, "exact_e11");
        add(1'b1, 1'b0, 4'b0000, "exact_e12");

        rn     = 1'b1;
        i_main = 1'b0;
        i_alt  = 1'b0;
        #1 rn  = 1'b0;

        foreach (vecs[k]) step(vecs[k].rn, vecs[k].i, 1'b0, vecs[k].exp, 1'b0, vecs[k].tag);

        // Bring Z to 1, start a fall, and pulse reset while cnt = 2.
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_up_e1");
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_up_e2");
        step(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, "mid_up_e3");
        step(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, "mid_up_e4");
        step(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, "mid_up_e5");
        step(1'b1, 1'b1, 1'b0, 4'b1100, 1'b0, "mid_up_e6");
        step(1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, "mid_up_e7");
        step(1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, "mid_dn_e1");
        step(1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, "mid_dn_e2");
        step(1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, "mid_dn_e3");
        step(1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, "mid_dn_cnt2");
        #2 rn = 1'b0;
        #1 check("async_rst_mid_qualify", {z0, zr0, zf0, qual0}, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "mid_rst_hold");
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, $sformatf("post_rst_%0d", k));

        // FILT_LEN=1, SYNC_STAGES=3: Z is I sampled three edges earlier.
        zp = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic iv;
            iv = (((k >> 1) & 1) == 0);
            hist.push_back(iv);
            zk = (k >= 3) ? hist[k-3] : 1'b0;
            step(1'b1, 1'b0, iv, {zk, zk & ~zp, ~zk & zp, 1'b0}, 1'b1,
                 $sformatf("f1_track_%0d", k));
            zp = zk;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
